// File: rtl/packet_framer.sv
`default_nettype none
// ============================================================================
//  Module   : packet_framer
//  Purpose  : Bit-serial packet transmitter: 16-bit sync header, command word,
//             then a counted payload pulled from a valid/ready bit source.
//  Revision : 1.0  initial release
// ============================================================================
module packet_framer #(
    parameter int          COMMAND_WIDTH     = 16,
    parameter logic [15:0] HEADER            = 16'hBACD,
    parameter int          PAYLOAD_LEN_WIDTH = 24
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [COMMAND_WIDTH-1:0]     command,
    input  logic [PAYLOAD_LEN_WIDTH-1:0] payload_len,
    input  logic                         payload_bit,
    input  logic                         payload_valid,
    output logic                         payload_ready,
    input  logic                         tx_ready,
    output logic                         output_bit,
    output logic                         is_new_output_bit,
    output logic                         busy,
    output logic                         done
);

    // The index must also cover the 16-bit header, hence the floor of 4 bits.
    localparam int CMD_CLOG = $clog2(COMMAND_WIDTH);
    localparam int IDX_W    = (CMD_CLOG < 4) ? 4 : CMD_CLOG;

    localparam logic [IDX_W-1:0]             C_HDR_LAST = IDX_W'(15);
    localparam logic [IDX_W-1:0]             C_CMD_LAST = IDX_W'(COMMAND_WIDTH - 1);
    localparam logic [PAYLOAD_LEN_WIDTH-1:0] C_CNT_ONE  = PAYLOAD_LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_COMMAND = 2'd2,
        S_PAYLOAD = 2'd3
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [COMMAND_WIDTH-1:0]       cmd_q, cmd_d;
    logic [PAYLOAD_LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic                           out_bit_q, out_bit_d;
    logic                           strobe_q, strobe_d;
    logic                           done_q, done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            cmd_q     <= '0;
            cnt_q     <= '0;
            out_bit_q <= 1'b0;
            strobe_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cmd_q     <= cmd_d;
            cnt_q     <= cnt_d;
            out_bit_q <= out_bit_d;
            strobe_q  <= strobe_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cmd_d     = cmd_q;
        cnt_d     = cnt_q;
        out_bit_d = out_bit_q;
        strobe_d  = 1'b0;
        done_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cmd_d   = command;
                    cnt_d   = payload_len;
                    idx_d   = C_HDR_LAST;
                    state_d = S_HEADER;
                end
            end

            S_HEADER: begin
                if (tx_ready) begin
                    out_bit_d = HEADER[idx_q[3:0]];
                    strobe_d  = 1'b1;
                    if (idx_q == '0) begin
                        idx_d   = C_CMD_LAST;
                        state_d = S_COMMAND;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end

            S_COMMAND: begin
                // The latched word shifts out MSB-first; idx only counts bits.
                if (tx_ready) begin
                    out_bit_d = cmd_q[COMMAND_WIDTH-1];
                    cmd_d     = {cmd_q[COMMAND_WIDTH-2:0], 1'b0};
                    strobe_d  = 1'b1;
                    if (idx_q == '0) begin
                        if (cnt_q == '0) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_PAYLOAD;
                        end
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end

            S_PAYLOAD: begin
                if (payload_valid && tx_ready) begin
                    out_bit_d = payload_bit;
                    strobe_d  = 1'b1;
                    cnt_d     = cnt_q - C_CNT_ONE;
                    if (cnt_q == C_CNT_ONE) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign payload_ready     = (state_q == S_PAYLOAD) && tx_ready;
    assign busy              = (state_q != S_IDLE);
    assign output_bit        = out_bit_q;
    assign is_new_output_bit = strobe_q;
    assign done              = done_q;

endmodule
`default_nettype wire

// File: tb/tb_packet_framer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_packet_framer
//  Purpose  : Self-checking bench; a bit-position reference model predicts
//             every strobe, bit, done pulse and payload_ready.
//  Revision : 1.0  initial release
// ============================================================================
module tb_packet_framer;

    localparam int          CW      = 16;
    localparam int          LW      = 24;
    localparam logic [15:0] HDR     = 16'hBACD;
    localparam int          HDR_CMD = 16 + CW;
    localparam int          BUDGET  = 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] command;
    logic [LW-1:0] payload_len;
    logic          payload_bit;
    logic          payload_valid;
    logic          payload_ready;
    logic          tx_ready;
    logic          output_bit;
    logic          is_new_output_bit;
    logic          busy;
    logic          done;

    packet_framer #(
        .COMMAND_WIDTH     (CW),
        .HEADER            (HDR),
        .PAYLOAD_LEN_WIDTH (LW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .command           (command),
        .payload_len       (payload_len),
        .payload_bit       (payload_bit),
        .payload_valid     (payload_valid),
        .payload_ready     (payload_ready),
        .tx_ready          (tx_ready),
        .output_bit        (output_bit),
        .is_new_output_bit (is_new_output_bit),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a packet is just a list of bits and a position in it.
    bit exp_bits[$];
    bit m_busy, m_out, m_strobe, m_done;
    int m_sent, m_total, m_strobes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_out = 0; m_strobe = 0; m_done = 0; m_sent = 0; m_total = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_out"},    {31'd0, output_bit},        32'd0);
        chk({tag, "_new"},    {31'd0, is_new_output_bit}, 32'd0);
        chk({tag, "_busy"},   {31'd0, busy},              32'd0);
        chk({tag, "_done"},   {31'd0, done},              32'd0);
        chk({tag, "_pready"}, {31'd0, payload_ready},     32'd0);
    endtask

    // One clock: drive inputs, check payload_ready, advance model, check outputs.
    task automatic tick(input logic st, input logic [CW-1:0] cmd, input logic [LW-1:0] len,
                        input logic tx, input logic vld);
        start         = st;
        command       = cmd;
        payload_len   = len;
        tx_ready      = tx;
        payload_valid = vld;
        payload_bit   = (m_busy && m_sent >= HDR_CMD) ? exp_bits[m_sent] : 1'($urandom_range(1));
        #1;
        chk("payload_ready", {31'd0, payload_ready},
            {31'd0, (m_busy && m_sent >= HDR_CMD && tx)});
        m_strobe = 0;
        m_done   = 0;
        if (!m_busy) begin
            if (st) begin
                exp_bits.delete();
                for (int i = 15; i >= 0; i--)     exp_bits.push_back(HDR[i]);
                for (int i = CW - 1; i >= 0; i--) exp_bits.push_back(cmd[i]);
                for (int i = 0; i < int'(len); i++) exp_bits.push_back(1'($urandom_range(1)));
                m_total = HDR_CMD + int'(len);
                m_sent  = 0;
                m_busy  = 1;
            end
        end else if (tx && (m_sent < HDR_CMD || vld)) begin
            m_out    = exp_bits[m_sent];
            m_sent++;
            m_strobe = 1;
            m_strobes++;
            if (m_sent == m_total) begin
                m_done = 1;
                m_busy = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("strobe",     {31'd0, is_new_output_bit}, {31'd0, m_strobe});
        chk("output_bit", {31'd0, output_bit},        {31'd0, m_out});
        chk("done",       {31'd0, done},              {31'd0, m_done});
        chk("busy",       {31'd0, busy},              {31'd0, m_busy});
    endtask

    // Modes: 0 full rate, 1 tx_ready alternating, 2 random, 3 valid gap,
    //        4 start held and command forced to FFFF while busy.
    task automatic run_packet(input logic [CW-1:0] cmd, input logic [LW-1:0] len,
                              input int mode, output int cycles);
        logic tx, vld, st;
        logic [CW-1:0] c;
        int k;
        m_strobes = 0;
        tick(1'b1, cmd, len, 1'b0, 1'b1);
        k = 1;
        while (m_busy && k < BUDGET) begin
            tx = 1'b1; vld = 1'b1; st = 1'b0; c = cmd;
            case (mode)
                1: tx = k[0];
                2: begin tx = ($urandom_range(3) != 0); vld = ($urandom_range(2) != 0); end
                3: vld = !(k >= 34 && k < 39);
                4: begin st = 1'b1; c = '1; end
                default: ;
            endcase
            tick(st, c, LW'($urandom), tx, vld);
            k++;
        end
        chk("budget", {31'd0, m_busy}, 32'd0);
        cycles = k;
    endtask

    initial begin
        int cyc;
        model_reset();
        rst = 1'b1; start = 0; command = '0; payload_len = '0;
        payload_bit = 0; payload_valid = 0; tx_ready = 0;
        #3;
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic packet: BACD, 0001, payload of 4 bits.
        run_packet(16'h0001, 24'd4, 0, cyc);
        chk("t1_strobes", m_strobes, 36);
        chk("t1_cycles",  cyc, 37);
        tick(1'b0, '0, '0, 1'b1, 1'b1);

        // Zero-length payload.
        run_packet(16'hA5F0, 24'd0, 0, cyc);
        chk("t2_strobes", m_strobes, 32);
        tick(1'b0, '0, '0, 1'b1, 1'b1);

        // tx_ready alternating: 72 edges from start to done inclusive.
        run_packet(16'h0001, 24'd4, 1, cyc);
        chk("t3_strobes", m_strobes, 36);
        chk("t3_cycles",  cyc, 72);

        // payload_valid gap of 5 cycles mid-payload.
        run_packet(16'h3C5A, 24'd10, 3, cyc);
        chk("t4_strobes", m_strobes, HDR_CMD + 10);
        chk("t4_cycles",  cyc, 1 + HDR_CMD + 10 + 5);

        // start held and command changed while busy; back-to-back packet follows.
        run_packet(16'h1234, 24'd3, 4, cyc);
        run_packet(16'hFFFF, 24'd2, 0, cyc);
        chk("t5_second_strobes", m_strobes, HDR_CMD + 2);

        // Asynchronous reset in the middle of the command field.
        start = 1'b0;
        tick(1'b1, 16'h0F0F, 24'd5, 1'b1, 1'b1);
        for (int i = 0; i < 20; i++) tick(1'b0, 16'h0F0F, 24'd5, 1'b1, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_outputs_zero("async_rst");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0, 16'h0F0F, 24'd5, 1'b1, 1'b1);
        run_packet(16'h0F0F, 24'd5, 0, cyc);
        chk("t6_strobes", m_strobes, HDR_CMD + 5);

        // Random packets under random back-pressure.
        for (int p = 0; p < 12; p++) begin
            run_packet(CW'($urandom), LW'($urandom_range(40)), 2, cyc);
            if ($urandom_range(1) != 0) tick(1'b0, '0, '0, 1'b1, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
